// File: rtl/pc_next_if.sv
// Fetch-side bundle for the next-PC sequencer.
// The master is the pipeline/fetch side; the slave is pc_next_unit.
interface pc_next_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_target;
    logic             jump;
    logic [WIDTH-1:0] jump_target;
    logic             fetch_ready;
    logic [WIDTH-1:0] pc;
    logic             pc_valid;
    logic [1:0]       pc_src;

    modport master (
        output stall, branch_taken, branch_target, jump, jump_target, fetch_ready,
        input  pc, pc_valid, pc_src
    );

    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target, fetch_ready,
        output pc, pc_valid, pc_src
    );
endinterface

// File: rtl/pc_next_unit.sv
// Program-counter register and next-PC sequencer.
// Chooses between PC+4, branch target and jump target each cycle. Redirects
// seen during a stall are parked in a pending register and released on the
// first unstalled cycle.
module pc_next_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic    clk,
    input  logic    rst_n,
    pc_next_if.slave bus
);
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    localparam logic [1:0] SRC_SEQ  = 2'b00;
    localparam logic [1:0] SRC_BR   = 2'b01;
    localparam logic [1:0] SRC_JMP  = 2'b10;
    localparam logic [1:0] SRC_PEND = 2'b11;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pc_valid_q, pc_valid_d;
    logic [1:0]       pc_src_q, pc_src_d;
    logic [WIDTH-1:0] pend_q, pend_d;

    // Redirect request: jump beats branch; targets are word-aligned on use.
    logic             redir;
    logic [WIDTH-1:0] redir_tgt;
    logic [1:0]       redir_src;

    // Resolve the redirect source for this cycle.
    always_comb begin
        redir     = bus.jump | bus.branch_taken;
        redir_tgt = bus.jump ? bus.jump_target : bus.branch_target;
        redir_tgt = {redir_tgt[WIDTH-1:2], 2'b00};
        redir_src = bus.jump ? SRC_JMP : SRC_BR;
    end

    // Next-state and next-PC selection.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        pc_src_d   = pc_src_q;
        pend_d     = pend_q;
        unique case (state_q)
            BOOT: begin
                // Redirects are ignored here; the PC stays at RESET_PC.
                state_d    = RUN;
                pc_valid_d = 1'b1;
            end
            RUN: begin
                if (!bus.stall) begin
                    if (redir) begin
                        // Flushes an un-accepted PC regardless of fetch_ready.
                        pc_d     = redir_tgt;
                        pc_src_d = redir_src;
                    end else if (pc_valid_q && bus.fetch_ready) begin
                        pc_d     = pc_q + WIDTH'(4);
                        pc_src_d = SRC_SEQ;
                    end
                end else if (redir) begin
                    pend_d  = redir_tgt;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (bus.stall) begin
                    if (redir) pend_d = redir_tgt;
                end else begin
                    // A redirect arriving on the release cycle is newer and wins.
                    if (redir) begin
                        pc_d     = redir_tgt;
                        pc_src_d = redir_src;
                    end else begin
                        pc_d     = pend_q;
                        pc_src_d = SRC_PEND;
                    end
                    pend_d  = '0;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            pc_src_q   <= SRC_SEQ;
            pend_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            pc_src_q   <= pc_src_d;
            pend_q     <= pend_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_valid = pc_valid_q;
    assign bus.pc_src   = pc_src_q;
endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit. Stimulus pushes hand-computed expectations
// into a scoreboard queue; a negedge monitor pops and compares.
module tb_pc_next_unit;
    localparam int WIDTH = 32;

    typedef struct {
        int              id;
        logic [WIDTH-1:0] pc;
        logic            vld;
        logic [1:0]      src;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   step_id = 0;

    pc_next_if #(.WIDTH(WIDTH)) bus ();

    pc_next_unit #(.WIDTH(WIDTH), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Monitor: compare the registered outputs against the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_total++;
            if (bus.pc === e.pc && bus.pc_valid === e.vld && bus.pc_src === e.src)
                n_pass++;
            else
                $display("FAIL step%0d: got pc=%h vld=%b src=%b, want pc=%h vld=%b src=%b",
                         e.id, bus.pc, bus.pc_valid, bus.pc_src, e.pc, e.vld, e.src);
        end
    end

    // One clock of stimulus; expectation is the output after that edge.
    task automatic cyc(input logic rn, input logic st,
                       input logic br, input logic [WIDTH-1:0] bt,
                       input logic jp, input logic [WIDTH-1:0] jt,
                       input logic fr,
                       input logic [WIDTH-1:0] epc, input logic ev, input logic [1:0] esrc);
        exp_t e;
        @(negedge clk);
        rst_n             = rn;
        bus.stall         = st;
        bus.branch_taken  = br;
        bus.branch_target = bt;
        bus.jump          = jp;
        bus.jump_target   = jt;
        bus.fetch_ready   = fr;
        @(posedge clk);
        #1;
        step_id++;
        e.id = step_id; e.pc = epc; e.vld = ev; e.src = esrc;
        sb.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
        bus.jump = 1'b0; bus.jump_target = '0; bus.fetch_ready = 1'b0;

        //   rn st br bt            jp jt            fr  pc            v  src
        cyc(0, 0, 0, 32'h0,       0, 32'h0,       0,  32'h0,        0, 2'b00); // reset
        cyc(0, 0, 0, 32'h0,       0, 32'h0,       1,  32'h0,        0, 2'b00);
        // BOOT: jump pulse ignored, valid rises
        cyc(1, 0, 0, 32'h0,       1, 32'h500,     1,  32'h0,        1, 2'b00);
        cyc(1, 0, 0, 32'h0,       0, 32'h0,       1,  32'h4,        1, 2'b00);
        cyc(1, 0, 0, 32'h0,       0, 32'h0,       1,  32'h8,        1, 2'b00);
        cyc(1, 0, 0, 32'h0,       0, 32'h0,       1,  32'hC,        1, 2'b00);
        cyc(1, 0, 0, 32'h0,       0, 32'h0,       1,  32'h10,       1, 2'b00);
        // fetch not ready for 3 cycles
        cyc(1, 0, 0, 32'h0,       0, 32'h0,       0,  32'h10,       1, 2'b00);
        cyc(1, 0, 0, 32'h0,       0, 32'h0,       0,  32'h10,       1, 2'b00);
        cyc(1, 0, 0, 32'h0,       0, 32'h0,       0,  32'h10,       1, 2'b00);
        cyc(1, 0, 0, 32'h0,       0, 32'h0,       1,  32'h14,       1, 2'b00);
        // branch + jump together: jump wins, aligned
        cyc(1, 0, 1, 32'h40,      1, 32'h83,      1,  32'h80,       1, 2'b10);
        // branch only, fetch not ready: still redirects, aligned
        cyc(1, 0, 1, 32'h41,      0, 32'h0,       0,  32'h40,       1, 2'b01);
        cyc(1, 0, 0, 32'h0,       0, 32'h0,       0,  32'h40,       1, 2'b01);
        // stalled branch then stalled jump; newest wins on release
        cyc(1, 1, 1, 32'h100,     0, 32'h0,       1,  32'h40,       1, 2'b01);
        cyc(1, 1, 0, 32'h0,       0, 32'h0,       1,  32'h40,       1, 2'b01);
        cyc(1, 1, 0, 32'h0,       1, 32'h200,     1,  32'h40,       1, 2'b01);
        cyc(1, 0, 0, 32'h0,       0, 32'h0,       0,  32'h200,      1, 2'b11);
        cyc(1, 0, 0, 32'h0,       0, 32'h0,       1,  32'h204,      1, 2'b00);
        // pending branch overridden by a same-cycle jump on release
        cyc(1, 1, 1, 32'h500,     0, 32'h0,       1,  32'h204,      1, 2'b00);
        cyc(1, 0, 0, 32'h0,       1, 32'h600,     0,  32'h600,      1, 2'b10);
        // stall without redirect freezes even with fetch_ready
        cyc(1, 1, 0, 32'h0,       0, 32'h0,       1,  32'h600,      1, 2'b10);
        // wrap-around
        cyc(1, 0, 0, 32'h0,       1, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFC, 1, 2'b10);
        cyc(1, 0, 0, 32'h0,       0, 32'h0,       1,  32'h0,        1, 2'b00);
        cyc(1, 0, 0, 32'h0,       0, 32'h0,       1,  32'h4,        1, 2'b00);
        // reset while PEND holds 0x300: target must be discarded
        cyc(1, 1, 1, 32'h300,     0, 32'h0,       1,  32'h4,        1, 2'b00);
        cyc(0, 0, 0, 32'h0,       0, 32'h0,       1,  32'h0,        0, 2'b00);
        cyc(1, 0, 0, 32'h0,       0, 32'h0,       0,  32'h0,        1, 2'b00);
        cyc(1, 0, 0, 32'h0,       0, 32'h0,       0,  32'h0,        1, 2'b00);
        cyc(1, 0, 0, 32'h0,       0, 32'h0,       1,  32'h4,        1, 2'b00);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_total++;
            $display("FAIL drain: got %0d entries left, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
